// File: rtl/edge_trigger_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_trigger_core_pkg
// Brief    : Shared widths and state encoding for the per-clock edge trigger.
// Revision : 1.0 - initial release
// ============================================================================
package edge_trigger_core_pkg;

    localparam int SAMPLE_WIDTH         = 16;
    localparam int SAMPLE_NUM_PER_CLK   = 8;
    localparam int RFDC_TDATA_WIDTH     = 128;
    localparam int ADC_RESOLUTION_WIDTH = 12;
    localparam int ADC_PAD_WIDTH        = SAMPLE_WIDTH - ADC_RESOLUTION_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } trig_state_t;

endpackage

`default_nettype wire

// File: rtl/edge_trigger_core_var_shift_delay.sv
`default_nettype none
// ============================================================================
// Module   : var_shift_delay
// Brief    : Variable-length delay line; DELAY=0 passes DIN straight through.
// Revision : 1.0 - initial release
// ============================================================================
module var_shift_delay #(
    parameter int DATA_WIDTH       = 1,
    parameter int MAX_DELAY_LENGTH = 2
) (
    input  logic                                CLK,
    input  logic [DATA_WIDTH-1:0]               DIN,
    input  logic [$clog2(MAX_DELAY_LENGTH):0]   DELAY,
    output logic [DATA_WIDTH-1:0]               DOUT
);

    localparam int                 c_dly_w   = $clog2(MAX_DELAY_LENGTH) + 1;
    localparam logic [c_dly_w-1:0] c_max_dly = c_dly_w'(MAX_DELAY_LENGTH);

    logic [DATA_WIDTH-1:0] r_sr [1:MAX_DELAY_LENGTH];
    logic [c_dly_w-1:0]    w_dly;

    always_ff @(posedge CLK) begin
        r_sr[1] <= DIN;
        for (int k = 2; k <= MAX_DELAY_LENGTH; k++) begin
            r_sr[k] <= r_sr[k-1];
        end
    end

    assign w_dly = (DELAY > c_max_dly) ? c_max_dly : DELAY;

    always_comb begin
        DOUT = DIN;
        for (int k = 1; k <= MAX_DELAY_LENGTH; k++) begin
            if (w_dly == c_dly_w'(k)) begin
                DOUT = r_sr[k];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/edge_trigger_core.sv
`default_nettype none
// ============================================================================
// Module   : edge_trigger_core
// Brief    : Threshold trigger with pre/post window extension and ADC saturation flag.
// Revision : 1.0 - initial release
// ============================================================================
module edge_trigger_core
    import edge_trigger_core_pkg::*;
#(
    parameter int MAX_PRE_ACQUISITION_LENGTH  = 2,
    parameter int MAX_POST_ACQUISITION_LENGTH = 2
) (
    input  logic                                             ACLK,
    input  logic                                             ARESET,
    input  logic                                             SET_CONFIG,
    input  logic                                             STOP,
    input  logic [RFDC_TDATA_WIDTH-1:0]                      S_AXIS_TDATA,
    input  logic                                             S_AXIS_TVALID,
    input  logic [RFDC_TDATA_WIDTH-1:0]                      H_S_AXIS_TDATA,
    input  logic signed [SAMPLE_WIDTH-1:0]                   RISING_EDGE_THRSHOLD,
    input  logic signed [SAMPLE_WIDTH-1:0]                   FALLING_EDGE_THRESHOLD,
    input  logic [$clog2(MAX_PRE_ACQUISITION_LENGTH):0]      PRE_ACQUISITION_LENGTH,
    input  logic [$clog2(MAX_POST_ACQUISITION_LENGTH):0]     POST_ACQUISITION_LENGTH,
    input  logic signed [ADC_RESOLUTION_WIDTH-1:0]           MODE_SWITCH_UPPER_THRESOLD,
    input  logic signed [ADC_RESOLUTION_WIDTH-1:0]           MODE_SWITCH_LOWER_THRESOLD,
    output logic                                             TRIGGER,
    output logic                                             SATURATION_FLAG
);

    localparam int c_pre_w  = $clog2(MAX_PRE_ACQUISITION_LENGTH) + 1;
    localparam int c_post_w = $clog2(MAX_POST_ACQUISITION_LENGTH) + 1;
    localparam int c_cnt_w  = ((c_pre_w > c_post_w) ? c_pre_w : c_post_w) + 1;

    logic                            w_clear;
    logic [SAMPLE_NUM_PER_CLK-1:0]   w_ge_r;
    logic [SAMPLE_NUM_PER_CLK-1:0]   w_ge_f;
    logic [SAMPLE_NUM_PER_CLK-1:0]   w_sat;
    logic signed [SAMPLE_WIDTH-1:0]  w_sat_hi;
    logic signed [SAMPLE_WIDTH-1:0]  w_sat_lo;
    logic [c_cnt_w-1:0]              w_len;
    trig_state_t                     w_state_nxt;

    logic [SAMPLE_NUM_PER_CLK-1:0]   r_ge_r;
    logic [SAMPLE_NUM_PER_CLK-1:0]   r_ge_f;
    logic                            r_valid1;
    logic                            r_any_r;
    logic                            r_any_f;
    logic                            r_valid2;
    trig_state_t                     r_state;
    logic [c_cnt_w-1:0]              r_cnt;
    logic [2:0]                      r_sat_pipe;

    assign w_clear = ARESET | SET_CONFIG;
    assign w_len   = c_cnt_w'(PRE_ACQUISITION_LENGTH) + c_cnt_w'(POST_ACQUISITION_LENGTH);

    // Limits scaled to the full 16-bit raw word: the 4 pad LSBs never change the
    // outcome of adc>=U or adc<=L, so compare {adc,pad} against {U,0000}/{L,1111}.
    assign w_sat_hi = $signed({MODE_SWITCH_UPPER_THRESOLD, {ADC_PAD_WIDTH{1'b0}}});
    assign w_sat_lo = $signed({MODE_SWITCH_LOWER_THRESOLD, {ADC_PAD_WIDTH{1'b1}}});

    for (genvar gi = 0; gi < SAMPLE_NUM_PER_CLK; gi++) begin : g_sample
        logic signed [SAMPLE_WIDTH-1:0] w_smp;
        logic signed [SAMPLE_WIDTH-1:0] w_raw;

        assign w_smp      = $signed(S_AXIS_TDATA[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
        assign w_raw      = $signed(H_S_AXIS_TDATA[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
        assign w_ge_r[gi] = (w_smp >= RISING_EDGE_THRSHOLD);
        assign w_ge_f[gi] = (w_smp >= FALLING_EDGE_THRESHOLD);
        assign w_sat[gi]  = (w_raw >= w_sat_hi) || (w_raw <= w_sat_lo);
    end

    always_ff @(posedge ACLK) begin
        if (w_clear) begin
            r_ge_r     <= '0;
            r_ge_f     <= '0;
            r_valid1   <= 1'b0;
            r_any_r    <= 1'b0;
            r_any_f    <= 1'b0;
            r_valid2   <= 1'b0;
            r_sat_pipe <= '0;
        end else begin
            r_ge_r     <= w_ge_r;
            r_ge_f     <= w_ge_f;
            r_valid1   <= S_AXIS_TVALID;
            r_any_r    <= (|r_ge_r) & r_valid1;
            r_any_f    <= (|r_ge_f) & r_valid1;
            r_valid2   <= r_valid1;
            r_sat_pipe <= {r_sat_pipe[1:0], |w_sat};
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (r_any_r && !STOP)        w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (!r_any_f || !r_valid2)   w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    // Reloading every active cycle lets a restart during the hold merge windows.
    always_ff @(posedge ACLK) begin
        if (w_clear) begin
            r_cnt <= '0;
        end else if (r_state == ST_ACTIVE) begin
            r_cnt <= w_len;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_w'(1);
        end
    end

    assign TRIGGER         = (r_state == ST_ACTIVE) || (r_cnt != '0);
    assign SATURATION_FLAG = r_sat_pipe[2];

endmodule

`default_nettype wire

// File: tb/tb_edge_trigger_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_trigger_core
// Brief    : Directed self-checking bench for edge_trigger_core and var_shift_delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_trigger_core;

    logic                ACLK;
    logic                ARESET;
    logic                SET_CONFIG;
    logic                STOP;
    logic [127:0]        S_AXIS_TDATA;
    logic                S_AXIS_TVALID;
    logic [127:0]        H_S_AXIS_TDATA;
    logic signed [15:0]  RISING_EDGE_THRSHOLD;
    logic signed [15:0]  FALLING_EDGE_THRESHOLD;
    logic [1:0]          PRE_ACQUISITION_LENGTH;
    logic [1:0]          POST_ACQUISITION_LENGTH;
    logic signed [11:0]  MODE_SWITCH_UPPER_THRESOLD;
    logic signed [11:0]  MODE_SWITCH_LOWER_THRESOLD;
    logic                TRIGGER;
    logic                SATURATION_FLAG;

    logic [7:0]          vs_din;
    logic [3:0]          vs_delay;
    logic [7:0]          vs_dout;

    int                  total;
    int                  bad;
    logic [127:0]        pat [16];

    edge_trigger_core #(
        .MAX_PRE_ACQUISITION_LENGTH  (2),
        .MAX_POST_ACQUISITION_LENGTH (2)
    ) u_dut (
        .ACLK                       (ACLK),
        .ARESET                     (ARESET),
        .SET_CONFIG                 (SET_CONFIG),
        .STOP                       (STOP),
        .S_AXIS_TDATA               (S_AXIS_TDATA),
        .S_AXIS_TVALID              (S_AXIS_TVALID),
        .H_S_AXIS_TDATA             (H_S_AXIS_TDATA),
        .RISING_EDGE_THRSHOLD       (RISING_EDGE_THRSHOLD),
        .FALLING_EDGE_THRESHOLD     (FALLING_EDGE_THRESHOLD),
        .PRE_ACQUISITION_LENGTH     (PRE_ACQUISITION_LENGTH),
        .POST_ACQUISITION_LENGTH    (POST_ACQUISITION_LENGTH),
        .MODE_SWITCH_UPPER_THRESOLD (MODE_SWITCH_UPPER_THRESOLD),
        .MODE_SWITCH_LOWER_THRESOLD (MODE_SWITCH_LOWER_THRESOLD),
        .TRIGGER                    (TRIGGER),
        .SATURATION_FLAG            (SATURATION_FLAG)
    );

    var_shift_delay #(
        .DATA_WIDTH       (8),
        .MAX_DELAY_LENGTH (5)
    ) u_vsd (
        .CLK   (ACLK),
        .DIN   (vs_din),
        .DELAY (vs_delay),
        .DOUT  (vs_dout)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] smp(input int idx, input logic [15:0] v);
        logic [127:0] w;
        w = '0;
        w[idx*16 +: 16] = v;
        return w;
    endfunction

    task automatic clr_pat();
        for (int k = 0; k < 16; k++) pat[k] = '0;
    endtask

    task automatic flush();
        S_AXIS_TDATA   = '0;
        H_S_AXIS_TDATA = '0;
        for (int k = 0; k < 10; k++) tick();
    endtask

    // Drives pat[j] in relative cycle j; TRIGGER expected high in cycles lo..hi.
    task automatic run_pat(input string tag, input int n, input int lo, input int hi,
                           input int stop_at, input int cfg_at, input int rst_at);
        for (int j = 0; j < n; j++) begin
            S_AXIS_TDATA = pat[j];
            if (j == stop_at) STOP = 1'b1;
            SET_CONFIG = (j == cfg_at);
            ARESET     = (j == rst_at);
            tick();
            chk($sformatf("%s_c%0d", tag, j + 1), {7'd0, TRIGGER},
                8'((j + 1 >= lo) && (j + 1 <= hi)));
        end
        SET_CONFIG = 1'b0;
        ARESET     = 1'b0;
        STOP       = 1'b0;
        clr_pat();
        flush();
    endtask

    // Raw word driven only in relative cycle 0; flag expected only in cycle 3 when hit.
    task automatic run_sat(input string tag, input logic [127:0] hword, input logic hit);
        for (int j = 0; j < 6; j++) begin
            H_S_AXIS_TDATA = (j == 0) ? hword : '0;
            tick();
            chk($sformatf("%s_c%0d", tag, j + 1), {7'd0, SATURATION_FLAG},
                8'(hit && (j + 1 == 3)));
        end
        flush();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr_pat();
        ARESET                     = 1'b1;
        SET_CONFIG                 = 1'b0;
        STOP                       = 1'b0;
        S_AXIS_TDATA               = '0;
        S_AXIS_TVALID              = 1'b1;
        H_S_AXIS_TDATA             = '0;
        RISING_EDGE_THRSHOLD       = 16'sd1024;
        FALLING_EDGE_THRESHOLD     = 16'sd1024;
        PRE_ACQUISITION_LENGTH     = 2'd1;
        POST_ACQUISITION_LENGTH    = 2'd1;
        MODE_SWITCH_UPPER_THRESOLD = 12'sd2047;
        MODE_SWITCH_LOWER_THRESOLD = -12'sd2048;
        vs_din                     = '0;
        vs_delay                   = '0;

        tick();
        tick();
        chk("reset_trigger", {7'd0, TRIGGER}, 8'd0);
        chk("reset_sat", {7'd0, SATURATION_FLAG}, 8'd0);
        ARESET = 1'b0;
        flush();

        // Single-cycle pulse: active for one clock plus PRE+POST=2 hold
        pat[0] = smp(3, 16'd1500);
        run_pat("single", 10, 3, 5, -1, -1, -1);

        // Five-cycle pulse, then a second pulse landing inside the hold
        for (int k = 0; k < 5; k++) pat[k] = smp(0, 16'd1200);
        pat[7] = smp(6, 16'd3000);
        run_pat("merge", 15, 3, 12, -1, -1, -1);

        for (int k = 0; k < 4; k++) pat[k] = smp(4, 16'd2000);
        run_pat("stop_block", 8, 1, 0, 0, -1, -1);

        for (int k = 0; k < 5; k++) pat[k] = smp(4, 16'd2000);
        run_pat("stop_mid", 12, 3, 9, 4, -1, -1);

        for (int k = 0; k < 5; k++) pat[k] = smp(1, 16'd2000);
        run_pat("set_config", 11, 3, 5, -1, 5, -1);

        for (int k = 0; k < 5; k++) pat[k] = smp(1, 16'd2000);
        run_pat("areset", 11, 3, 5, -1, -1, 5);

        pat[0] = smp(1, 16'd1023) | smp(7, 16'h8000) | smp(2, 16'hFFFF);
        run_pat("below_thr", 6, 1, 0, -1, -1, -1);

        pat[0] = smp(7, 16'd1024);
        run_pat("at_thr", 8, 3, 5, -1, -1, -1);

        FALLING_EDGE_THRESHOLD = 16'sd512;
        pat[0] = smp(2, 16'd1500);
        pat[1] = smp(2, 16'd600);
        pat[2] = smp(2, 16'd600);
        run_pat("hyst", 10, 3, 7, -1, -1, -1);
        FALLING_EDGE_THRESHOLD = 16'sd1024;

        S_AXIS_TVALID = 1'b0;
        for (int k = 0; k < 3; k++) pat[k] = smp(0, 16'd2000);
        run_pat("invalid", 7, 1, 0, -1, -1, -1);
        S_AXIS_TVALID = 1'b1;

        PRE_ACQUISITION_LENGTH  = 2'd0;
        POST_ACQUISITION_LENGTH = 2'd0;
        pat[0] = smp(0, 16'd2000);
        run_pat("len0", 6, 3, 3, -1, -1, -1);

        PRE_ACQUISITION_LENGTH  = 2'd2;
        POST_ACQUISITION_LENGTH = 2'd2;
        pat[0] = smp(5, 16'd2000);
        run_pat("len4", 10, 3, 7, -1, -1, -1);
        PRE_ACQUISITION_LENGTH  = 2'd1;
        POST_ACQUISITION_LENGTH = 2'd1;

        run_sat("sat_hi", smp(5, 16'h7FF0), 1'b1);
        S_AXIS_TVALID = 1'b0;
        STOP          = 1'b1;
        run_sat("sat_lo", smp(5, 16'h8000), 1'b1);
        S_AXIS_TVALID = 1'b1;
        STOP          = 1'b0;
        run_sat("sat_none", smp(5, 16'h7FEF) | smp(2, 16'h8010), 1'b0);
        run_sat("sat_lo_nib", smp(0, 16'h800F), 1'b1);

        vs_delay = 4'd0;
        for (int k = 0; k < 4; k++) begin
            vs_din = 8'(k * 3 + 1);
            #1;
            chk($sformatf("vsd_d0_k%0d", k), vs_dout, 8'(k * 3 + 1));
            tick();
        end
        vs_delay = 4'd3;
        for (int k = 0; k < 8; k++) begin
            vs_din = 8'(100 + k);
            #1;
            if (k >= 3) chk($sformatf("vsd_d3_k%0d", k), vs_dout, 8'(100 + k - 3));
            tick();
        end
        vs_delay = 4'd7;
        for (int k = 0; k < 9; k++) begin
            vs_din = 8'(200 + k);
            #1;
            if (k >= 5) chk($sformatf("vsd_d7_k%0d", k), vs_dout, 8'(200 + k - 5));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
